alu_share_arb: RTL

Two-port arbiter and sequencer that shares one combinational `alu_4bit` datapath (8-bit `a`/`b`, 3-bit `sel`, 8-bit `z`) between two requesters. Each requester presents an operation over a valid/ready handshake. The block grants requesters round-robin, registers operands into the ALU, captures the result, and returns it over a per-port valid/ready response channel. It sits between the front-end units that issue ALU operations and the single ALU instance.

---
 rtl/alu_share_arb_pkg.sv | 14 +
 rtl/alu_share_arb_rr_arb2.sv | 16 +
 rtl/alu_share_arb.sv | 126 ++++++++++++
 3 files changed

// File: rtl/alu_share_arb_pkg.sv
// Shared types and defaults for the two-port ALU sharing arbiter.
// Defaults match the single alu_4bit datapath instance.
package alu_share_arb_pkg;

    localparam int ALU_WIDTH = 8;
    localparam int ALU_SEL_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/alu_share_arb_rr_arb2.sv
// Two-input round-robin picker: a single requester always wins, and under
// contention the port that was not served last wins.
module rr_arb2 (
    input  logic [1:0] valid,
    input  logic       last_grant,
    output logic [1:0] grant
);

    always_comb begin
        grant = valid;
        if (valid == 2'b11) begin
            grant = last_grant ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/alu_share_arb.sv
// Shares one combinational ALU between two valid/ready requesters:
// accept (IDLE) -> drive ALU and capture (EXEC) -> hold result (RESP).
module alu_share_arb
    import alu_share_arb_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH,
    parameter int SEL_W = ALU_SEL_W,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    input  logic             req1_valid,
    output logic             req0_ready,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [SEL_W-1:0] req0_sel,
    input  logic [SEL_W-1:0] req1_sel,
    output logic             rsp0_valid,
    output logic             rsp1_valid,
    input  logic             rsp0_ready,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp0_z,
    output logic [WIDTH-1:0] rsp1_z,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [SEL_W-1:0] alu_sel,
    input  logic [WIDTH-1:0] alu_z,
    output logic             busy,
    output logic [CNT_W-1:0] ops_done
);

    state_t             state, state_nxt;
    logic [1:0]         grant;
    logic               accept;
    logic               rsp_fire;
    logic               gnt_idx;
    logic               last_grant;
    logic [WIDTH-1:0]   op_a, op_b, result;
    logic [SEL_W-1:0]   op_sel;
    logic [CNT_W-1:0]   ops_cnt;

    rr_arb2 u_arb (
        .valid      ({req1_valid, req0_valid}),
        .last_grant (last_grant),
        .grant      (grant)
    );

    // NOTE: every output of this block gets a default first, so no path through
    // the case leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_nxt  = state;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        rsp0_valid = 1'b0;
        rsp1_valid = 1'b0;
        accept     = 1'b0;
        rsp_fire   = 1'b0;
        case (state)
            ST_IDLE: begin
                req0_ready = grant[0];
                req1_ready = grant[1];
                accept     = |grant;
                if (accept) state_nxt = ST_EXEC;
            end
            ST_EXEC: state_nxt = ST_RESP;
            ST_RESP: begin
                rsp0_valid = ~gnt_idx;
                rsp1_valid = gnt_idx;
                rsp_fire   = gnt_idx ? rsp1_ready : rsp0_ready;
                if (rsp_fire) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Operand registers feed the ALU directly and keep their last values
    // between operations.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt_idx    <= 1'b0;
            op_a       <= '0;
            op_b       <= '0;
            op_sel     <= '0;
            result     <= '0;
            last_grant <= 1'b1;
            ops_cnt    <= '0;
        end else begin
            if (accept) begin
                gnt_idx <= grant[1];
                op_a    <= grant[1] ? req1_a   : req0_a;
                op_b    <= grant[1] ? req1_b   : req0_b;
                op_sel  <= grant[1] ? req1_sel : req0_sel;
            end
            if (state == ST_EXEC) begin
                result <= alu_z;
            end
            if (rsp_fire) begin
                last_grant <= gnt_idx;
                ops_cnt    <= ops_cnt + CNT_W'(1);
            end
        end
    end

    assign alu_a    = op_a;
    assign alu_b    = op_b;
    assign alu_sel  = op_sel;
    assign rsp0_z   = result;
    assign rsp1_z   = result;
    assign busy     = (state != ST_IDLE);
    assign ops_done = ops_cnt;

endmodule
